// File: rtl/pipe_hazard_controller_pkg.sv
// Shared encodings for the pipeline hazard controller: MIPS opcode/funct
// values, next-PC / ALU / writeback select codes, debug FSM states and
// forward-select codes, plus the decoded-control bundle type.
//
// Optional feature macro used by the design files: HAZARD_FORWARD_EN.
package pipe_hazard_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR  = 6'h08;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [2:0] PC_NEXT = 3'd0;
  localparam logic [2:0] PC_JUMP = 3'd1;
  localparam logic [2:0] PC_JR   = 3'd2;
  localparam logic [2:0] PC_BEQ  = 3'd3;
  localparam logic [2:0] PC_BNE  = 3'd4;

  localparam logic [1:0] EXE_A_RS   = 2'd0;
  localparam logic [1:0] EXE_A_LINK = 2'd1;
  localparam logic [1:0] EXE_B_RT   = 2'd0;
  localparam logic [1:0] EXE_B_IMM  = 2'd1;
  localparam logic [1:0] EXE_B_LINK = 2'd2;

  localparam logic [3:0] EXE_ALU_ADD = 4'd0;
  localparam logic [3:0] EXE_ALU_SUB = 4'd1;
  localparam logic [3:0] EXE_ALU_AND = 4'd2;
  localparam logic [3:0] EXE_ALU_OR  = 4'd3;
  localparam logic [3:0] EXE_ALU_SLT = 4'd4;

  localparam logic [1:0] WB_ADDR_RD   = 2'd0;
  localparam logic [1:0] WB_ADDR_RT   = 2'd1;
  localparam logic [1:0] WB_ADDR_LINK = 2'd2;
  localparam logic       WB_DATA_ALU  = 1'b0;
  localparam logic       WB_DATA_MEM  = 1'b1;

  localparam logic [1:0] DBG_RUN  = 2'd0;
  localparam logic [1:0] DBG_HALT = 2'd1;
  localparam logic [1:0] DBG_STEP = 2'd2;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_EXE = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  typedef struct packed {
    logic [2:0] pc_src;
    logic       imm_ext;
    logic [1:0] exe_a_src;
    logic [1:0] exe_b_src;
    logic [3:0] exe_alu_oper;
    logic       mem_ren;
    logic       mem_wen;
    logic [1:0] wb_addr_src;
    logic       wb_data_src;
    logic       wb_wen;
    logic       unrecognized;
    logic       rs_used;
    logic       rt_used;
    logic       is_jump;
  } ctrl_t;

endpackage

// File: rtl/pipe_hazard_controller_scoreboard.sv
// hazard_scoreboard: shift register of in-flight destinations after ID
// (index 0 = EXE, 1 = MEM, PIPE_DEPTH-1 = WB) plus RAW match logic.
//
// Ports
//   clk, rst          clock, synchronous active-high reset (clears all entries)
//   shift_en          advance the pipeline by one stage
//   load_bubble       entry 0 receives an empty slot instead of ID's destination
//   ld_valid/ld_waddr/ld_is_load   ID-stage destination being issued
//   rs_addr/rt_addr, rs_used/rt_used   ID-stage sources
//   stall             a used source must wait
//   fwd_a/fwd_b       forward select for rs/rt (FWD_* codes)
//
// Macro HAZARD_FORWARD_EN: stall only on load-use, forward EXE/MEM results.
module hazard_scoreboard
  import pipe_hazard_controller_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int REG_AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              load_bubble,
  input  logic              ld_valid,
  input  logic [REG_AW-1:0] ld_waddr,
  input  logic              ld_is_load,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic              rs_used,
  input  logic              rt_used,
  output logic              stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  logic [PIPE_DEPTH-1:0]             valid_q;
  logic [PIPE_DEPTH-1:0]             is_load_q;
  logic [PIPE_DEPTH-1:0][REG_AW-1:0] waddr_q;
  logic [REG_AW-1:0]                 ent_waddr;
  logic                              ent_valid;
  logic                              ent_is_load;

  assign ent_valid   = ld_valid & ~load_bubble;
  assign ent_is_load = ld_is_load & ent_valid;
  assign ent_waddr   = ent_valid ? ld_waddr : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      is_load_q <= '0;
      waddr_q   <= '0;
    end else if (shift_en) begin
      valid_q   <= {valid_q[PIPE_DEPTH-2:0], ent_valid};
      is_load_q <= {is_load_q[PIPE_DEPTH-2:0], ent_is_load};
      waddr_q   <= {waddr_q[PIPE_DEPTH-2:0], ent_waddr};
    end
  end

  // The WB slot is kept for visibility only: the regfile is write-first,
  // so a reader in ID already sees that value.
  logic [PIPE_DEPTH+REG_AW:0] unused_wb_slot;
  assign unused_wb_slot = {valid_q[PIPE_DEPTH-1], waddr_q[PIPE_DEPTH-1], is_load_q};

  // Returns {stall, fwd}. The loop runs oldest-to-youngest so the nearest
  // producer wins; PIPE_DEPTH-1 doubles as "no match".
  function automatic logic [2:0] resolve(input logic used, input logic [REG_AW-1:0] addr);
    int         near;
    logic       stl;
    logic [1:0] fwd;
    near = PIPE_DEPTH - 1;
    for (int i = PIPE_DEPTH - 2; i >= 0; i--) begin
      if (used && addr != '0 && valid_q[i] && waddr_q[i] == addr) near = i;
    end
`ifdef HAZARD_FORWARD_EN
    // Load data exists only after MEM; producers older than MEM (deep
    // pipelines) have no bypass path and still interlock.
    stl = (near == 0 && is_load_q[0]) || (near >= 2 && near < PIPE_DEPTH - 1);
    if (stl || near == PIPE_DEPTH - 1) fwd = FWD_REG;
    else if (near == 0)                fwd = FWD_EXE;
    else                               fwd = FWD_MEM;
`else
    stl = (near != PIPE_DEPTH - 1);
    fwd = FWD_REG;
`endif
    return {stl, fwd};
  endfunction

  logic [2:0] res_a, res_b;

  always_comb begin
    res_a = resolve(rs_used, rs_addr);
    res_b = resolve(rt_used, rt_addr);
  end

  assign stall = res_a[2] | res_b[2];
  assign fwd_a = res_a[1:0];
  assign fwd_b = res_b[1:0];

endmodule

// File: rtl/pipe_hazard_controller.sv
// pipe_hazard_controller: ID-stage decode for the 5-stage MIPS pipeline,
// RAW hazard interlock via an in-flight scoreboard, stall/flush generation
// and a halt/step debug FSM that gates the whole datapath.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   inst, inst_valid      ID-stage instruction and its valid flag
//   branch_taken          EXE-stage branch resolved taken
//   debug_en, debug_step, debug_steps   halt request, step request, step length
//   pc_src..unrecognized  decoded datapath controls (wb_wen squashed on stall/flush)
//   if_en, id_en          stage register enables
//   if_flush, id_flush    load a bubble into IF/ID, ID/EXE
//   fwd_a, fwd_b          operand forward selects
//   cpu_rst, cpu_en       datapath reset and global enable
//   dbg_state             debug FSM state
//
// Macro HAZARD_FORWARD_EN: forwarding with load-use stall only; otherwise
// full interlock and fwd_a/fwd_b stay 0.
//
// Debug FSM
//   state | meaning
//   RUN   | free running, cpu_en=1
//   HALT  | datapath frozen, cpu_en=0, waits for a step edge
//   STEP  | runs cnt cycles then returns to HALT (or RUN if debug_en dropped)
module pipe_hazard_controller
  import pipe_hazard_controller_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int REG_AW     = 5,
  parameter int STEP_CW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        inst,
  input  logic               inst_valid,
  input  logic               branch_taken,
  input  logic               debug_en,
  input  logic               debug_step,
  input  logic [STEP_CW-1:0] debug_steps,
  output logic [2:0]         pc_src,
  output logic               imm_ext,
  output logic [1:0]         exe_a_src,
  output logic [1:0]         exe_b_src,
  output logic [3:0]         exe_alu_oper,
  output logic               mem_ren,
  output logic               mem_wen,
  output logic [1:0]         wb_addr_src,
  output logic               wb_data_src,
  output logic               wb_wen,
  output logic               unrecognized,
  output logic               if_en,
  output logic               id_en,
  output logic               if_flush,
  output logic               id_flush,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               cpu_rst,
  output logic               cpu_en,
  output logic [1:0]         dbg_state
);

  logic [5:0] opcode, funct;
  ctrl_t      c;

  assign opcode = inst[31:26];
  assign funct  = inst[5:0];

  logic [4:0] unused_shamt;
  assign unused_shamt = inst[10:6];

  always_comb begin
    c              = '0;
    c.pc_src       = PC_NEXT;
    c.exe_a_src    = EXE_A_RS;
    c.exe_b_src    = EXE_B_RT;
    c.exe_alu_oper = EXE_ALU_ADD;
    c.wb_addr_src  = WB_ADDR_RD;
    c.wb_data_src  = WB_DATA_ALU;
    case (opcode)
      OP_RTYPE: begin
        c.rs_used = 1'b1;
        case (funct)
          FUNCT_JR: begin
            c.pc_src  = PC_JR;
            c.is_jump = 1'b1;
          end
          FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT: begin
            c.rt_used = 1'b1;
            c.wb_wen  = 1'b1;
            case (funct)
              FUNCT_SUB: c.exe_alu_oper = EXE_ALU_SUB;
              FUNCT_AND: c.exe_alu_oper = EXE_ALU_AND;
              FUNCT_OR:  c.exe_alu_oper = EXE_ALU_OR;
              FUNCT_SLT: c.exe_alu_oper = EXE_ALU_SLT;
              default:   c.exe_alu_oper = EXE_ALU_ADD;
            endcase
          end
          default: begin
            c.rs_used      = 1'b0;
            c.unrecognized = 1'b1;
          end
        endcase
      end
      OP_J: begin
        c.pc_src  = PC_JUMP;
        c.is_jump = 1'b1;
      end
      OP_JAL: begin
        // Link value is computed in EXE as pc + 4.
        c.pc_src      = PC_JUMP;
        c.is_jump     = 1'b1;
        c.exe_a_src   = EXE_A_LINK;
        c.exe_b_src   = EXE_B_LINK;
        c.wb_addr_src = WB_ADDR_LINK;
        c.wb_wen      = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        c.pc_src       = (opcode == OP_BEQ) ? PC_BEQ : PC_BNE;
        c.imm_ext      = 1'b1;
        c.exe_alu_oper = EXE_ALU_SUB;
        c.rs_used      = 1'b1;
        c.rt_used      = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        c.imm_ext      = (opcode == OP_ADDI);
        c.exe_b_src    = EXE_B_IMM;
        c.exe_alu_oper = (opcode == OP_ADDI) ? EXE_ALU_ADD :
                         (opcode == OP_ANDI) ? EXE_ALU_AND : EXE_ALU_OR;
        c.wb_addr_src  = WB_ADDR_RT;
        c.wb_wen       = 1'b1;
        c.rs_used      = 1'b1;
      end
      OP_LW: begin
        c.imm_ext     = 1'b1;
        c.exe_b_src   = EXE_B_IMM;
        c.mem_ren     = 1'b1;
        c.wb_addr_src = WB_ADDR_RT;
        c.wb_data_src = WB_DATA_MEM;
        c.wb_wen      = 1'b1;
        c.rs_used     = 1'b1;
      end
      OP_SW: begin
        c.imm_ext   = 1'b1;
        c.exe_b_src = EXE_B_IMM;
        c.mem_wen   = 1'b1;
        c.rs_used   = 1'b1;
        c.rt_used   = 1'b1;
      end
      default: c.unrecognized = 1'b1;
    endcase
  end

  logic [REG_AW-1:0] dec_waddr;

  always_comb begin
    case (c.wb_addr_src)
      WB_ADDR_RT:   dec_waddr = REG_AW'(inst[20:16]);
      WB_ADDR_LINK: dec_waddr = REG_AW'(5'd31);
      default:      dec_waddr = REG_AW'(inst[15:11]);
    endcase
  end

  // Debug FSM
  logic [1:0]         dbg_q, dbg_d;
  logic [STEP_CW-1:0] cnt_q, cnt_d;
  logic               step_prev_q;
  logic               step_rise;

  assign step_rise = debug_step & ~step_prev_q;

  always_comb begin
    dbg_d = dbg_q;
    cnt_d = cnt_q;
    case (dbg_q)
      DBG_RUN: if (debug_en) dbg_d = DBG_HALT;
      DBG_HALT: begin
        if (!debug_en) begin
          dbg_d = DBG_RUN;
        end else if (step_rise) begin
          dbg_d = DBG_STEP;
          cnt_d = (debug_steps == '0) ? STEP_CW'(1) : debug_steps;
        end
      end
      DBG_STEP: begin
        cnt_d = cnt_q - STEP_CW'(1);
        // <= also catches a zero count, which cannot be loaded but must not hang.
        if (cnt_q <= STEP_CW'(1)) dbg_d = debug_en ? DBG_HALT : DBG_RUN;
      end
      default: dbg_d = DBG_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_q       <= DBG_RUN;
      cnt_q       <= '0;
      step_prev_q <= 1'b0;
    end else begin
      dbg_q       <= dbg_d;
      cnt_q       <= cnt_d;
      step_prev_q <= debug_step;
    end
  end

  assign dbg_state = dbg_q;
  assign cpu_en    = (dbg_q != DBG_HALT);
  assign cpu_rst   = rst;

  // Hazard scoreboard and pipeline control
  logic       sb_stall;
  logic [1:0] sb_fwd_a, sb_fwd_b;
  logic       act;
  logic       stall_eff;

  hazard_scoreboard #(
    .PIPE_DEPTH (PIPE_DEPTH),
    .REG_AW     (REG_AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .shift_en    (cpu_en),
    .load_bubble (id_flush),
    .ld_valid    (inst_valid & c.wb_wen & (dec_waddr != '0)),
    .ld_waddr    (dec_waddr),
    .ld_is_load  (c.mem_ren),
    .rs_addr     (REG_AW'(inst[25:21])),
    .rt_addr     (REG_AW'(inst[20:16])),
    .rs_used     (inst_valid & c.rs_used),
    .rt_used     (inst_valid & c.rt_used),
    .stall       (sb_stall),
    .fwd_a       (sb_fwd_a),
    .fwd_b       (sb_fwd_b)
  );

  // A taken branch squashes the ID instruction anyway, so it overrides a stall.
  assign act       = cpu_en & ~rst;
  assign stall_eff = act & sb_stall & ~branch_taken;

  assign if_en    = cpu_en & ~stall_eff;
  assign id_en    = cpu_en;
  assign if_flush = act & (branch_taken | (c.is_jump & inst_valid & ~stall_eff));
  assign id_flush = act & (branch_taken | stall_eff);
  assign fwd_a    = rst ? FWD_REG : sb_fwd_a;
  assign fwd_b    = rst ? FWD_REG : sb_fwd_b;

  assign pc_src       = c.pc_src;
  assign imm_ext      = c.imm_ext;
  assign exe_a_src    = c.exe_a_src;
  assign exe_b_src    = c.exe_b_src;
  assign exe_alu_oper = c.exe_alu_oper;
  assign mem_ren      = c.mem_ren;
  assign mem_wen      = c.mem_wen;
  assign wb_addr_src  = c.wb_addr_src;
  assign wb_data_src  = c.wb_data_src;
  assign wb_wen       = c.wb_wen & ~id_flush;
  assign unrecognized = c.unrecognized;

endmodule

// File: tb/tb_pipe_hazard_controller.sv
// Directed bench for pipe_hazard_controller: decode, RAW stalls, flushes,
// debug halt/step and reset behaviour. Expectations follow HAZARD_FORWARD_EN.
module tb_pipe_hazard_controller;

  localparam logic [31:0] I_IDLE   = 32'h0000_0020; // ADD $0,$0,$0
  localparam logic [31:0] I_ADD3   = 32'h0022_1820; // ADD $3,$1,$2
  localparam logic [31:0] I_SUB4   = 32'h0061_2022; // SUB $4,$3,$1
  localparam logic [31:0] I_LW5    = 32'h8C05_0000; // LW  $5,0($0)
  localparam logic [31:0] I_ADD6   = 32'h00A5_3020; // ADD $6,$5,$5
  localparam logic [31:0] I_ADDI0  = 32'h2000_0001; // ADDI $0,$0,1
  localparam logic [31:0] I_ADD1   = 32'h0000_0820; // ADD $1,$0,$0
  localparam logic [31:0] I_J      = 32'h0800_0010; // J 0x10
  localparam logic [31:0] I_BAD    = 32'hFC00_0000;

`ifdef HAZARD_FORWARD_EN
  localparam int T1_STALLS = 1 - 1;
  localparam int T1_FWD    = 1;
  localparam int T2_STALLS = 1;
  localparam int T2_FWD    = 2;
`else
  localparam int T1_STALLS = 2;
  localparam int T1_FWD    = 0;
  localparam int T2_STALLS = 2;
  localparam int T2_FWD    = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        inst_valid, branch_taken, debug_en, debug_step;
  logic [7:0]  debug_steps;
  logic [2:0]  pc_src;
  logic        imm_ext;
  logic [1:0]  exe_a_src, exe_b_src;
  logic [3:0]  exe_alu_oper;
  logic        mem_ren, mem_wen;
  logic [1:0]  wb_addr_src;
  logic        wb_data_src, wb_wen, unrecognized;
  logic        if_en, id_en, if_flush, id_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic        cpu_rst, cpu_en;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  pipe_hazard_controller dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
    .branch_taken(branch_taken), .debug_en(debug_en), .debug_step(debug_step),
    .debug_steps(debug_steps), .pc_src(pc_src), .imm_ext(imm_ext),
    .exe_a_src(exe_a_src), .exe_b_src(exe_b_src), .exe_alu_oper(exe_alu_oper),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .wb_addr_src(wb_addr_src),
    .wb_data_src(wb_data_src), .wb_wen(wb_wen), .unrecognized(unrecognized),
    .if_en(if_en), .id_en(id_en), .if_flush(if_flush), .id_flush(id_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .cpu_rst(cpu_rst), .cpu_en(cpu_en),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic v);
    inst = i;
    inst_valid = v;
    #1;
  endtask

  task automatic drain();
    drive(I_IDLE, 1'b0);
    repeat (4) tick();
  endtask

  // Counts consecutive stall cycles (bounded), checking IF is frozen each time.
  task automatic count_stalls(input string tag, output int cnt);
    cnt = 0;
    while (id_flush === 1'b1 && cnt < 8) begin
      chk({tag, "_if_en_stalled"}, {31'd0, if_en}, 32'd0);
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; inst = I_IDLE; inst_valid = 1'b0; branch_taken = 1'b0;
    debug_en = 1'b0; debug_step = 1'b0; debug_steps = 8'd0;
    repeat (3) tick();
    chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("rst_dbg_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_cpu_en", {31'd0, cpu_en}, 32'd1);
    chk("rst_if_en", {31'd0, if_en}, 32'd1);
    chk("rst_flushes", {30'd0, if_flush, id_flush}, 32'd0);
    rst = 1'b0;
    tick();
    chk("run_cpu_rst", {31'd0, cpu_rst}, 32'd0);

    // 1: ADD $3 then SUB $4,$3,$1
    drive(I_ADD3, 1'b1);
    chk("t1_add_wb_wen", {31'd0, wb_wen}, 32'd1);
    chk("t1_add_id_flush", {31'd0, id_flush}, 32'd0);
    tick();
    drive(I_SUB4, 1'b1);
    chk("t1_sub_alu", {28'd0, exe_alu_oper}, 32'd1);
    count_stalls("t1", n);
    chk("t1_stall_cycles", n, T1_STALLS);
    chk("t1_issue_if_en", {31'd0, if_en}, 32'd1);
    chk("t1_issue_fwd_a", {30'd0, fwd_a}, T1_FWD);
    chk("t1_issue_fwd_b", {30'd0, fwd_b}, 32'd0);
    drain();

    // 2: LW $5 then ADD $6,$5,$5
    drive(I_LW5, 1'b1);
    chk("t2_lw_ctrl", {imm_ext, mem_ren, mem_wen, wb_data_src, wb_addr_src, exe_b_src},
        {1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 2'd1});
    tick();
    drive(I_ADD6, 1'b1);
    count_stalls("t2", n);
    chk("t2_stall_cycles", n, T2_STALLS);
    chk("t2_issue_fwd_a", {30'd0, fwd_a}, T2_FWD);
    chk("t2_issue_fwd_b", {30'd0, fwd_b}, T2_FWD);
    drain();

    // 3: writes to r0 never hazard
    drive(I_ADDI0, 1'b1);
    tick();
    drive(I_ADD1, 1'b1);
    chk("t3_r0_id_flush", {31'd0, id_flush}, 32'd0);
    chk("t3_r0_if_en", {31'd0, if_en}, 32'd1);
    chk("t3_r0_fwd", {30'd0, fwd_a}, 32'd0);
    drain();

    // 4: taken branch overrides a pending RAW stall; J flushes IF once
    drive(I_ADD3, 1'b1);
    tick();
    branch_taken = 1'b1;
    drive(I_SUB4, 1'b1);
    chk("t4_br_if_flush", {31'd0, if_flush}, 32'd1);
    chk("t4_br_id_flush", {31'd0, id_flush}, 32'd1);
    chk("t4_br_if_en", {31'd0, if_en}, 32'd1);
    chk("t4_br_wb_wen", {31'd0, wb_wen}, 32'd0);
    branch_taken = 1'b0;
    drain();
    drive(I_J, 1'b1);
    chk("t4_j_if_flush", {31'd0, if_flush}, 32'd1);
    chk("t4_j_id_flush", {31'd0, id_flush}, 32'd0);
    chk("t4_j_pc_src", {29'd0, pc_src}, 32'd1);
    tick();
    drive(I_IDLE, 1'b0);
    chk("t4_j_flush_once", {31'd0, if_flush}, 32'd0);

    // 7: unrecognized opcode
    drive(I_BAD, 1'b1);
    chk("t7_unrec", {31'd0, unrecognized}, 32'd1);
    chk("t7_wb_wen", {31'd0, wb_wen}, 32'd0);
    chk("t7_mem_wen", {31'd0, mem_wen}, 32'd0);
    drain();

    // 5: halt and step
    debug_en = 1'b1;
    tick();
    chk("t5_halt_state", {30'd0, dbg_state}, 32'd1);
    chk("t5_halt_enables", {29'd0, cpu_en, if_en, id_en}, 32'd0);
    debug_steps = 8'd3;
    debug_step = 1'b1;
    tick();
    n = 0;
    while (cpu_en === 1'b1 && n < 10) begin
      n++;
      tick();
    end
    chk("t5_step3_cycles", n, 32'd3);
    chk("t5_step3_back_halt", {30'd0, dbg_state}, 32'd1);
    debug_step = 1'b0;
    tick();
    debug_steps = 8'd0;
    debug_step = 1'b1;
    tick();
    n = 0;
    while (cpu_en === 1'b1 && n < 10) begin
      n++;
      tick();
    end
    chk("t5_step0_cycles", n, 32'd1);
    debug_step = 1'b0;
    tick();

    // 6: reset on the 2nd STEP cycle
    debug_steps = 8'd3;
    debug_step = 1'b1;
    drive(I_ADD3, 1'b1);
    tick();
    chk("t6_step_state", {30'd0, dbg_state}, 32'd2);
    tick();
    rst = 1'b1;
    debug_en = 1'b0;
    drive(I_SUB4, 1'b1);
    chk("t6_rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("t6_rst_flushes", {30'd0, if_flush, id_flush}, 32'd0);
    chk("t6_rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    chk("t6_rst_if_en", {31'd0, if_en}, 32'd1);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_after_state", {30'd0, dbg_state}, 32'd0);
    chk("t6_sb_empty_stall", {31'd0, id_flush}, 32'd0);
    chk("t6_sb_empty_fwd", {30'd0, fwd_a}, 32'd0);
    debug_step = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
